// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// write/read FSM state types and the byte-address to word-index helper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COLLECT,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_t;

   // Byte address to 32-bit word index; the two low address bits are dropped
   // so misaligned addresses land on the containing word.
   function automatic logic [31:0] word_idx(input logic [31:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/axi_lite_slave_wr_fsm.sv
// AXI4-Lite write channel handler: collects AW and W independently (either
// order or together), issues a one-cycle commit strobe with index/data/strobe
// once both are held, and owns the B response until it is accepted.
module axi_lite_slave_wr_fsm
   import axi_lite_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     i_awaddr,
   input  logic                              i_awvalid,
   output logic                              o_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   i_wstrb,
   input  logic                              i_wvalid,
   output logic                              o_wready,
   output logic [1:0]                        o_bresp,
   output logic                              o_bvalid,
   input  logic                              i_bready,
   output logic                              o_commit,
   output logic [C_S_AXI_ADDR_WIDTH-3:0]     o_idx,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     o_data,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   o_strb
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam int BW    = C_S_AXI_DATA_WIDTH / 8;

   wr_state_t                    r_state,   w_state_n;
   logic                         r_aw_held, w_aw_held_n;
   logic                         r_w_held,  w_w_held_n;
   logic [IDX_W-1:0]             r_idx,     w_idx_n;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_data,   w_data_n;
   logic [BW-1:0]                r_strb,    w_strb_n;
   logic                         r_awready, w_awready_n;
   logic                         r_wready,  w_wready_n;
   logic                         r_bvalid,  w_bvalid_n;
   logic [1:0]                   r_bresp,   w_bresp_n;
   logic                         w_commit;

   assign w_commit = (r_state == W_COLLECT) && r_aw_held && r_w_held;

   // State and holding registers; READY outputs are registered copies of
   // the next-state "nothing held and no response pending" condition.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_idx     <= '0;
         r_data    <= '0;
         r_strb    <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_state   <= w_state_n;
         r_aw_held <= w_aw_held_n;
         r_w_held  <= w_w_held_n;
         r_idx     <= w_idx_n;
         r_data    <= w_data_n;
         r_strb    <= w_strb_n;
         r_awready <= w_awready_n;
         r_wready  <= w_wready_n;
         r_bvalid  <= w_bvalid_n;
         r_bresp   <= w_bresp_n;
      end
   end

   // Next-state: capture AW/W on their handshakes, commit when both held,
   // then hold the B response until BREADY.
   always_comb begin
      w_state_n   = r_state;
      w_aw_held_n = r_aw_held;
      w_w_held_n  = r_w_held;
      w_idx_n     = r_idx;
      w_data_n    = r_data;
      w_strb_n    = r_strb;
      w_bvalid_n  = r_bvalid;
      w_bresp_n   = r_bresp;
      case (r_state)
         W_IDLE, W_COLLECT: begin
            if (i_awvalid && r_awready) begin
               w_aw_held_n = 1'b1;
               w_idx_n     = IDX_W'(word_idx(32'(i_awaddr)));
            end
            if (i_wvalid && r_wready) begin
               w_w_held_n = 1'b1;
               w_data_n   = i_wdata;
               w_strb_n   = i_wstrb;
            end
            if (w_commit) begin
               w_state_n   = W_RESP;
               w_aw_held_n = 1'b0;
               w_w_held_n  = 1'b0;
               w_bvalid_n  = 1'b1;
               w_bresp_n   = (32'(r_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
            end else if (w_aw_held_n || w_w_held_n) begin
               w_state_n = W_COLLECT;
            end
         end
         W_RESP: begin
            if (r_bvalid && i_bready) begin
               w_bvalid_n = 1'b0;
               w_state_n  = W_IDLE;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
      w_awready_n = !w_aw_held_n && !w_bvalid_n;
      w_wready_n  = !w_w_held_n && !w_bvalid_n;
   end

   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_commit  = w_commit;
   assign o_idx     = r_idx;
   assign o_data    = r_data;
   assign o_strb    = r_strb;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: NUM_REGS 32-bit registers with byte-strobed
// writes, per-register write-commit pulses and an independent read path.
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                                 ACLK,
   input  logic                                 ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam int BW    = C_S_AXI_DATA_WIDTH / 8;

   logic                                   w_commit;
   logic [IDX_W-1:0]                       w_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]          w_data;
   logic [BW-1:0]                          w_strb;
   logic                                   w_wr_ok;
   logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0]                    r_pulse;

   rd_state_t                              r_rstate,  w_rstate_n;
   logic                                   r_arready, w_arready_n;
   logic                                   r_rvalid,  w_rvalid_n;
   logic [C_S_AXI_DATA_WIDTH-1:0]          r_rdata,   w_rdata_n;
   logic [1:0]                             r_rresp,   w_rresp_n;
   logic [IDX_W-1:0]                       w_ar_idx;
   logic                                   w_ar_ok;
   logic                                   w_unused_prot;

   assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   axi_lite_slave_wr_fsm #(
      .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
      .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
      .NUM_REGS           (NUM_REGS)
   ) u_wr_fsm (
      .i_clk     (ACLK),
      .i_rst     (ARESET),
      .i_awaddr  (S_AXI_AWADDR),
      .i_awvalid (S_AXI_AWVALID),
      .o_awready (S_AXI_AWREADY),
      .i_wdata   (S_AXI_WDATA),
      .i_wstrb   (S_AXI_WSTRB),
      .i_wvalid  (S_AXI_WVALID),
      .o_wready  (S_AXI_WREADY),
      .o_bresp   (S_AXI_BRESP),
      .o_bvalid  (S_AXI_BVALID),
      .i_bready  (S_AXI_BREADY),
      .o_commit  (w_commit),
      .o_idx     (w_idx),
      .o_data    (w_data),
      .o_strb    (w_strb)
   );

   assign w_wr_ok  = 32'(w_idx) < NUM_REGS;
   assign w_ar_idx = IDX_W'(word_idx(32'(S_AXI_ARADDR)));
   assign w_ar_ok  = 32'(w_ar_idx) < NUM_REGS;

   // Register array: strobed byte update and a one-cycle pulse on each
   // in-range commit (the pulse fires even when no strobe bit is set).
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_regs  <= '0;
         r_pulse <= '0;
      end else begin
         r_pulse <= '0;
         if (w_commit && w_wr_ok) begin
            r_pulse[w_idx] <= 1'b1;
            for (int unsigned b = 0; b < BW; b++) begin
               if (w_strb[b]) r_regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
         end
      end
   end

   // Read path registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rstate  <= w_rstate_n;
         r_arready <= w_arready_n;
         r_rvalid  <= w_rvalid_n;
         r_rdata   <= w_rdata_n;
         r_rresp   <= w_rresp_n;
      end
   end

   // Read next-state: data is sampled on the AR handshake edge (so a write
   // committing on that edge is not visible) and RVALID follows one edge later.
   always_comb begin
      w_rstate_n  = r_rstate;
      w_arready_n = r_arready;
      w_rvalid_n  = r_rvalid;
      w_rdata_n   = r_rdata;
      w_rresp_n   = r_rresp;
      case (r_rstate)
         R_IDLE: begin
            w_arready_n = 1'b1;
            if (S_AXI_ARVALID && r_arready) begin
               w_rstate_n  = R_RESP;
               w_arready_n = 1'b0;
               w_rdata_n   = w_ar_ok ? r_regs[w_ar_idx] : '0;
               w_rresp_n   = w_ar_ok ? RESP_OKAY : RESP_SLVERR;
            end
         end
         R_RESP: begin
            w_rvalid_n = 1'b1;
            if (r_rvalid && S_AXI_RREADY) begin
               w_rvalid_n  = 1'b0;
               w_arready_n = 1'b1;
               w_rstate_n  = R_IDLE;
            end
         end
         default: w_rstate_n = R_IDLE;
      endcase
   end

   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign reg_q         = r_regs;
   assign reg_wr_pulse  = r_pulse;

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder holding NUM_REGS 32-bit control/status registers. It sits behind the AXI VIP master in block designs and serves the accesses that master issues: sequential writes to offsets 0x0..0xC and readback. It exports register contents and per-register write-commit pulses to the downstream classifier datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte-address width; word index is ADDR[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers; must be <= 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  single clock, rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
reg_q  out  NUM_REGS*32  register contents; reg i is at [32*i+31:32*i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written.

Behaviour:
- Reset (ARESET=1, asynchronous): all READY and VALID outputs 0; BRESP, RRESP, RDATA, reg_q and reg_wr_pulse 0; AW/W holding flags cleared. A transaction in flight is dropped and never answered.
- Write path, FSM states W_IDLE, W_COLLECT, W_RESP:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY=1 when no AW is held and BVALID=0. WREADY=1 when no W is held and BVALID=0. Both are registered outputs.
  - When both AW and W are held at edge T: commit at edge T+1. Strobed bytes of reg[idx] are updated, reg_wr_pulse[idx]=1 for exactly that cycle, and BVALID=1 with BRESP=OKAY (2'b00).
  - idx >= NUM_REGS: no register change, no pulse, BRESP=SLVERR (2'b10).
  - WSTRB=0: no register bits change, but the pulse still fires and BRESP=OKAY.
  - BVALID and BRESP hold until BREADY. Back to W_IDLE on the B handshake; AWREADY/WREADY can rise the cycle after.
  - One outstanding write at most.
- Read path, states R_IDLE, R_RESP:
  - ARREADY=1 when RVALID=0.
  - AR handshake at edge T: RDATA = reg[idx] sampled at T, with RVALID=1 and RRESP=OKAY at edge T+1.
  - idx out of range: RDATA=0 and RRESP=SLVERR.
  - RDATA, RRESP and RVALID hold until RREADY. One outstanding read at most.
- Address bits [1:0] are ignored; misaligned addresses access the containing word.
- A read and a write commit to the same register on the same edge: the read returns the pre-write value.
- Read and write paths are fully independent; neither stalls the other.
- BREADY/RREADY held low indefinitely: the block stalls that channel only and never drops the response.

Decomposition:
- Shared package axi_lite_pkg: constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; write-FSM and read-FSM state enums; a word-index extraction function.
- One sub-module, axi_lite_slave_wr_fsm: AW/W collection, holding registers and the B channel. Its outputs are a commit strobe, idx, data and strobe.
- The top level holds the register array and the read path.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back the same addresses -> reads return 0x1..0x4 with RRESP=0; reg_wr_pulse bits 0..3 each pulse once.
- Write with W presented 3 cycles before AW (WDATA=0xDEADBEEF, addr 0x4) -> WREADY drops after the W handshake; commit and BVALID one cycle after the AW handshake; reg 1 = 0xDEADBEEF.
- reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg0 reads 0xFF34FF78.
- NUM_REGS=3, write 0xAA to 0xC -> BRESP=2'b10, no reg_wr_pulse; a read of 0xC returns RDATA=0, RRESP=2'b10.
- BREADY low for 10 cycles after a write -> BVALID stays 1 and AWREADY stays 0 throughout; a concurrent read still completes.
- Assert ARESET mid-write after the AW handshake only -> all outputs 0 immediately; after release, a fresh write to 0x0 of 0x5 completes normally with BRESP=0.
